// File: rtl/buffer_escrita.sv
// buffer_escrita: posted-store FIFO between nRisc's data port and data memory, with load forwarding.
// Define BUFFER_ESCRITA_CONTADORES_EN to build the NumFwd/NumStall saturating counters.
module buffer_escrita #(
  parameter int PROF = 4,
  parameter int LARG = 8
) (
  input  logic            Clock,
  input  logic            reset,
  input  logic            MemWrite,
  input  logic            MemRead,
  input  logic [LARG-1:0] Endereco,
  input  logic [LARG-1:0] EscreveDado,
  output logic [LARG-1:0] LeDado,
  output logic            Stall,
  output logic [LARG-1:0] MemEndereco,
  output logic [LARG-1:0] MemEscreveDado,
  output logic            MemWriteOut,
  output logic            MemReadOut,
  input  logic [LARG-1:0] MemLeDado,
  input  logic            MemPronto,
  output logic [7:0]      NumFwd,
  output logic [7:0]      NumStall
);

  localparam int PTRW = (PROF > 1) ? $clog2(PROF) : 1;
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] CHEIO = CNTW'(PROF);

  typedef enum logic [1:0] {OCIOSO, ESCRITA, LEITURA, ENTREGA} EstadoT;

  EstadoT            estado;
  EstadoT            proxEstado;
  logic [LARG-1:0]   fifoEnd  [PROF];
  logic [LARG-1:0]   fifoDado [PROF];
  logic [PTRW-1:0]   cabeca;
  logic [PTRW-1:0]   cauda;
  logic [CNTW-1:0]   contagem;
  logic [LARG-1:0]   dadoLido;
  logic [PTRW-1:0]   scanIdx;
  logic              acerto;
  logic [LARG-1:0]   dadoAcerto;
  logic              cheio;
  logic              enfileira;
  logic              desenfileira;
  logic              faltaLeitura;
  logic              encaminha;

  // Scan oldest to youngest so the youngest matching store overrides older ones.
  always_comb begin
    acerto     = 1'b0;
    dadoAcerto = '0;
    scanIdx    = cabeca;
    for (int i = 0; i < PROF; i++) begin
      scanIdx = cabeca + PTRW'(i);
      if ((CNTW'(i) < contagem) && (fifoEnd[scanIdx] == Endereco)) begin
        acerto     = 1'b1;
        dadoAcerto = fifoDado[scanIdx];
      end
    end
  end

  assign cheio        = (contagem == CHEIO);
  assign enfileira    = MemWrite && !cheio;
  assign desenfileira = (estado == ESCRITA) && MemPronto;
  assign faltaLeitura = MemRead && !acerto && (estado != ENTREGA);
  assign encaminha    = MemRead && acerto && (estado != ENTREGA);

  // Memory strobes decode the state register only; a load miss wins over draining.
  always_comb begin
    proxEstado     = estado;
    LeDado         = '0;
    MemWriteOut    = 1'b0;
    MemReadOut     = 1'b0;
    MemEndereco    = '0;
    MemEscreveDado = '0;
    case (estado)
      OCIOSO: begin
        if (faltaLeitura)
          proxEstado = LEITURA;
        else if (contagem != '0)
          proxEstado = ESCRITA;
      end
      ESCRITA: begin
        MemWriteOut    = 1'b1;
        MemEndereco    = fifoEnd[cabeca];
        MemEscreveDado = fifoDado[cabeca];
        if (MemPronto)
          proxEstado = OCIOSO;
      end
      LEITURA: begin
        MemReadOut  = 1'b1;
        MemEndereco = Endereco;
        if (MemPronto)
          proxEstado = ENTREGA;
      end
      ENTREGA: begin
        LeDado     = dadoLido;
        proxEstado = OCIOSO;
      end
      default: proxEstado = OCIOSO;
    endcase
    if (encaminha)
      LeDado = dadoAcerto;
    Stall = faltaLeitura || (MemWrite && cheio);
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      estado   <= OCIOSO;
      cabeca   <= '0;
      cauda    <= '0;
      contagem <= '0;
      dadoLido <= '0;
    end else begin
      estado <= proxEstado;
      if (enfileira)
        cauda <= cauda + 1'b1;
      if (desenfileira)
        cabeca <= cabeca + 1'b1;
      case ({enfileira, desenfileira})
        2'b10:   contagem <= contagem + 1'b1;
        2'b01:   contagem <= contagem - 1'b1;
        default: contagem <= contagem;
      endcase
      if ((estado == LEITURA) && MemPronto)
        dadoLido <= MemLeDado;
    end
  end

  // Entry storage needs no reset: an entry is only visible while counted.
  always_ff @(posedge Clock) begin
    if (enfileira) begin
      fifoEnd[cauda]  <= Endereco;
      fifoDado[cauda] <= EscreveDado;
    end
  end

`ifdef BUFFER_ESCRITA_CONTADORES_EN
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      NumFwd   <= '0;
      NumStall <= '0;
    end else begin
      if (encaminha && (NumFwd != 8'hFF))
        NumFwd <= NumFwd + 1'b1;
      if (Stall && (NumStall != 8'hFF))
        NumStall <= NumStall + 1'b1;
    end
  end
`else
  assign NumFwd   = '0;
  assign NumStall = '0;
`endif

endmodule

// File: tb/tb_buffer_escrita.sv
// Self-checking bench for buffer_escrita: directed scenarios plus random store/load traffic
// checked against an architectural memory image and a queue of pending stores.
module tb_buffer_escrita;

  localparam int PROF = 4;
  localparam int LARG = 8;

  logic            Clock = 1'b0;
  logic            reset;
  logic            MemWrite;
  logic            MemRead;
  logic [LARG-1:0] Endereco;
  logic [LARG-1:0] EscreveDado;
  logic [LARG-1:0] LeDado;
  logic            Stall;
  logic [LARG-1:0] MemEndereco;
  logic [LARG-1:0] MemEscreveDado;
  logic            MemWriteOut;
  logic            MemReadOut;
  logic [LARG-1:0] MemLeDado;
  logic            MemPronto;
  logic [7:0]      NumFwd;
  logic [7:0]      NumStall;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } StoreT;

  StoreT      pending[$];
  StoreT      expectedOrder[$];
  StoreT      seen[$];
  logic [7:0] archMem [256];
  logic [7:0] physMem [256];
  int         checks = 0;
  int         passes = 0;

  buffer_escrita #(.PROF(PROF), .LARG(LARG)) dut (
    .Clock(Clock), .reset(reset),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .Endereco(Endereco), .EscreveDado(EscreveDado),
    .LeDado(LeDado), .Stall(Stall),
    .MemEndereco(MemEndereco), .MemEscreveDado(MemEscreveDado),
    .MemWriteOut(MemWriteOut), .MemReadOut(MemReadOut),
    .MemLeDado(MemLeDado), .MemPronto(MemPronto),
    .NumFwd(NumFwd), .NumStall(NumStall)
  );

  always #5 Clock = ~Clock;

  assign MemLeDado = physMem[MemEndereco];

  // Drive one cycle's inputs just after the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic w, input logic r, input logic [7:0] a,
                               input logic [7:0] d, input logic p);
    MemWrite    = w;
    MemRead     = r;
    Endereco    = a;
    EscreveDado = d;
    MemPronto   = p;
    #1;
  endtask

  // Advance the models by what the coming rising edge commits, then move to the next falling edge.
  task automatic tick();
    int    sizeBefore;
    StoreT e;
    sizeBefore = pending.size();
    if (MemWriteOut === 1'b1 && MemPronto === 1'b1) begin
      e.addr = MemEndereco;
      e.data = MemEscreveDado;
      seen.push_back(e);
      physMem[MemEndereco] = MemEscreveDado;
      if (pending.size() > 0)
        e = pending.pop_front();
    end
    if (MemWrite && sizeBefore < PROF) begin
      e.addr = Endereco;
      e.data = EscreveDado;
      pending.push_back(e);
      expectedOrder.push_back(e);
      archMem[Endereco] = EscreveDado;
    end
    @(negedge Clock);
  endtask

  function automatic logic inPending(input logic [7:0] a);
    foreach (pending[i])
      if (pending[i].addr == a)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge Clock);
    @(negedge Clock);
    pending.delete();
    seen.delete();
    expectedOrder.delete();
    for (int i = 0; i < 256; i++)
      archMem[i] = physMem[i];
    reset = 1'b1;
  endtask

  task automatic drainAll(input int budget, output logic drained);
    drained = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (pending.size() == 0 && MemWriteOut !== 1'b1) begin
        drained = 1'b1;
        break;
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      tick();
    end
    if (pending.size() == 0 && MemWriteOut !== 1'b1)
      drained = 1'b1;
  endtask

  task automatic test_reset();
    logic anyStrobe;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({LeDado, Stall, MemEndereco, MemEscreveDado, MemWriteOut, MemReadOut, NumFwd, NumStall} !== '0)
      $display("[TB] FAIL reset_outputs: got LeDado=%h Stall=%b MemEnd=%h MemDado=%h Wr=%b Rd=%b Fwd=%0d St=%0d want all 0",
               LeDado, Stall, MemEndereco, MemEscreveDado, MemWriteOut, MemReadOut, NumFwd, NumStall);
    else passes++;
    doReset();
    anyStrobe = 1'b0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      if (MemWriteOut !== 1'b0 || MemReadOut !== 1'b0 || Stall !== 1'b0)
        anyStrobe = 1'b1;
      tick();
    end
    checks++;
    if (anyStrobe !== 1'b0) $display("[TB] FAIL idle_strobes: got activity=%b want 0", anyStrobe);
    else passes++;
  endtask

  task automatic test_store_drain();
    logic drained;
    logic anyWrite;
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h10, 8'hAA, 1'b1);
    checks++;
    if (Stall !== 1'b0) $display("[TB] FAIL store_0x10_stall: got %b want 0", Stall); else passes++;
    tick();
    applyStimulus(1'b1, 1'b0, 8'h11, 8'hBB, 1'b1);
    checks++;
    if (Stall !== 1'b0) $display("[TB] FAIL store_0x11_stall: got %b want 0", Stall); else passes++;
    tick();
    drainAll(30, drained);
    checks++;
    if (drained !== 1'b1) $display("[TB] FAIL drain_timeout: got %0d pending want 0", pending.size()); else passes++;
    checks++;
    if (seen.size() != 2) $display("[TB] FAIL drain_count: got %0d writes want 2", seen.size()); else passes++;
    checks++;
    if (seen[0] !== {8'h10, 8'hAA}) $display("[TB] FAIL drain_first: got %h want 10aa", seen[0]); else passes++;
    checks++;
    if (seen[1] !== {8'h11, 8'hBB}) $display("[TB] FAIL drain_second: got %h want 11bb", seen[1]); else passes++;
    anyWrite = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      if (MemWriteOut !== 1'b0) anyWrite = 1'b1;
      tick();
    end
    checks++;
    if (anyWrite !== 1'b0) $display("[TB] FAIL empty_no_write: got MemWriteOut activity=%b want 0", anyWrite); else passes++;
  endtask

  task automatic test_full_stall();
    logic drained;
    doReset();
    for (int i = 0; i < PROF; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h50 + i), 8'(8'hD0 + i), 1'b0);
      checks++;
      if (Stall !== 1'b0) $display("[TB] FAIL fill_stall_%0d: got %b want 0", i, Stall); else passes++;
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 8'h54, 8'hD4, (c == 2) ? 1'b1 : 1'b0);
      checks++;
      if (Stall !== 1'b1) $display("[TB] FAIL full_stall_%0d: got %b want 1", c, Stall); else passes++;
      tick();
    end
    applyStimulus(1'b1, 1'b0, 8'h54, 8'hD4, 1'b0);
    checks++;
    if (Stall !== 1'b0) $display("[TB] FAIL full_accept: got %b want 0", Stall); else passes++;
    tick();
`ifdef BUFFER_ESCRITA_CONTADORES_EN
    checks++;
    if (NumStall !== 8'd3) $display("[TB] FAIL num_stall: got %0d want 3", NumStall); else passes++;
`endif
    drainAll(60, drained);
    checks++;
    if (drained !== 1'b1 || seen.size() != 5)
      $display("[TB] FAIL full_drain: got drained=%b writes=%0d want 1 and 5", drained, seen.size());
    else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (seen[i] !== {8'(8'h50 + i), 8'(8'hD0 + i)})
        $display("[TB] FAIL full_order_%0d: got %h want %h", i, seen[i], {8'(8'h50 + i), 8'(8'hD0 + i)});
      else passes++;
    end
  endtask

  task automatic test_forward();
    logic drained;
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h01, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h02, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h20, 8'h00, 1'b0);
    checks++;
    if (Stall !== 1'b0) $display("[TB] FAIL fwd_stall: got %b want 0", Stall); else passes++;
    checks++;
    if (LeDado !== 8'h02) $display("[TB] FAIL fwd_youngest: got %h want 02", LeDado); else passes++;
    tick();
`ifdef BUFFER_ESCRITA_CONTADORES_EN
    checks++;
    if (NumFwd !== 8'd1) $display("[TB] FAIL num_fwd: got %0d want 1", NumFwd); else passes++;
`endif
    drainAll(40, drained);
    checks++;
    if (drained !== 1'b1 || seen.size() != 2 || seen[0] !== {8'h20, 8'h01} || seen[1] !== {8'h20, 8'h02})
      $display("[TB] FAIL fwd_drain: got drained=%b n=%0d w0=%h w1=%h want 1 2 2001 2002",
               drained, seen.size(), seen[0], seen[1]);
    else passes++;
  endtask

  task automatic test_load_miss();
    logic drained;
    doReset();
    physMem[8'h40] = 8'h5C;
    archMem[8'h40] = 8'h5C;
    applyStimulus(1'b1, 1'b0, 8'h30, 8'h77, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h40, 8'h00, 1'b1);
    checks++;
    if (Stall !== 1'b1 || MemWriteOut !== 1'b0 || MemReadOut !== 1'b0)
      $display("[TB] FAIL miss_request: got Stall=%b Wr=%b Rd=%b want 1 0 0", Stall, MemWriteOut, MemReadOut);
    else passes++;
    tick();
    applyStimulus(1'b0, 1'b1, 8'h40, 8'h00, 1'b1);
    checks++;
    if (Stall !== 1'b1 || MemReadOut !== 1'b1 || MemWriteOut !== 1'b0 || MemEndereco !== 8'h40)
      $display("[TB] FAIL miss_leitura: got Stall=%b Rd=%b Wr=%b addr=%h want 1 1 0 40",
               Stall, MemReadOut, MemWriteOut, MemEndereco);
    else passes++;
    tick();
    applyStimulus(1'b0, 1'b1, 8'h40, 8'h00, 1'b1);
    checks++;
    if (Stall !== 1'b0 || LeDado !== 8'h5C || MemReadOut !== 1'b0)
      $display("[TB] FAIL miss_entrega: got Stall=%b LeDado=%h Rd=%b want 0 5c 0", Stall, LeDado, MemReadOut);
    else passes++;
    tick();
    drainAll(30, drained);
    checks++;
    if (drained !== 1'b1 || seen.size() != 1 || seen[0] !== {8'h30, 8'h77})
      $display("[TB] FAIL miss_then_drain: got drained=%b n=%0d w0=%h want 1 1 3077", drained, seen.size(), seen[0]);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic anyWrite;
    logic done;
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h60 + i), 8'(8'hC0 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    checks++;
    if (MemWriteOut !== 1'b1) $display("[TB] FAIL mid_escrita: got MemWriteOut=%b want 1", MemWriteOut); else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (MemWriteOut !== 1'b0 || MemEndereco !== 8'h00)
      $display("[TB] FAIL mid_reset_strobe: got Wr=%b addr=%h want 0 00", MemWriteOut, MemEndereco);
    else passes++;
    @(negedge Clock);
    pending.delete();
    seen.delete();
    expectedOrder.delete();
    for (int i = 0; i < 256; i++)
      archMem[i] = physMem[i];
    reset = 1'b1;
    anyWrite = 1'b0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      if (MemWriteOut !== 1'b0) anyWrite = 1'b1;
      tick();
    end
    checks++;
    if (anyWrite !== 1'b0) $display("[TB] FAIL mid_no_writes: got activity=%b want 0", anyWrite); else passes++;
    applyStimulus(1'b0, 1'b1, 8'h61, 8'h00, 1'b1);
    checks++;
    if (Stall !== 1'b1) $display("[TB] FAIL mid_discarded_miss: got Stall=%b want 1", Stall); else passes++;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      tick();
      applyStimulus(1'b0, 1'b1, 8'h61, 8'h00, 1'b1);
      if (Stall === 1'b0) done = 1'b1;
    end
    checks++;
    if (done !== 1'b1 || LeDado !== archMem[8'h61])
      $display("[TB] FAIL mid_reload: got done=%b LeDado=%h want 1 %h", done, LeDado, archMem[8'h61]);
    else passes++;
    tick();
  endtask

  task automatic test_random();
    logic       drained;
    logic       done;
    logic       first;
    logic       isStore;
    logic       isLoad;
    logic       expStall;
    logic [7:0] a;
    logic [7:0] d;
    int         op;
    doReset();
    for (int n = 0; n < 300; n++) begin
      op      = $urandom_range(0, 19);
      isStore = (op < 8);
      isLoad  = (op >= 8 && op < 15);
      a       = 8'(8'hE0 + $urandom_range(0, 7));
      d       = 8'($urandom_range(0, 255));
      first   = 1'b1;
      done    = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        applyStimulus(isStore, isLoad, a, d, ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
        checks++;
        if (MemWriteOut === 1'b1 && MemReadOut === 1'b1)
          $display("[TB] FAIL rnd_strobe_overlap op%0d: got Wr=1 Rd=1 want exclusive", n);
        else passes++;
        if (isStore) begin
          expStall = (pending.size() == PROF);
          checks++;
          if (Stall !== expStall) $display("[TB] FAIL rnd_store_stall op%0d: got %b want %b", n, Stall, expStall);
          else passes++;
          done = !expStall;
        end else if (isLoad) begin
          if (first) begin
            expStall = !inPending(a);
            checks++;
            if (Stall !== expStall) $display("[TB] FAIL rnd_load_hit op%0d addr %h: got Stall=%b want %b", n, a, Stall, expStall);
            else passes++;
          end
          if (Stall === 1'b0) begin
            checks++;
            if (LeDado !== archMem[a]) $display("[TB] FAIL rnd_load_data op%0d addr %h: got %h want %h", n, a, LeDado, archMem[a]);
            else passes++;
            done = 1'b1;
          end
        end else begin
          done = 1'b1;
        end
        first = 1'b0;
        tick();
      end
      if (!done) begin
        checks++;
        $display("[TB] FAIL rnd_timeout op%0d: got no completion in 40 cycles want completion", n);
      end
    end
    drainAll(100, drained);
    checks++;
    if (drained !== 1'b1 || seen.size() != expectedOrder.size())
      $display("[TB] FAIL rnd_drain: got drained=%b writes=%0d want 1 and %0d", drained, seen.size(), expectedOrder.size());
    else passes++;
    foreach (expectedOrder[i]) begin
      checks++;
      if (seen[i] !== expectedOrder[i]) $display("[TB] FAIL rnd_order_%0d: got %h want %h", i, seen[i], expectedOrder[i]);
      else passes++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    Endereco    = '0;
    EscreveDado = '0;
    MemPronto   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      physMem[i] = 8'($urandom_range(0, 255));
      archMem[i] = physMem[i];
    end
    test_reset();
    test_store_drain();
    test_full_stall();
    test_forward();
    test_load_miss();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
